// File: rtl/booth_pp_gen_if.sv
// rtl/booth_pp_gen_if.sv - operand/column-vector handshake bundle for booth_pp_gen
interface booth_pp_gen_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] N [64];
  logic [13:0] Cin;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, N, Cin
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, N, Cin
  );
endinterface

// File: rtl/booth_pp_gen.sv
// rtl/booth_pp_gen.sv - radix-4 Booth partial-product generator, 32x32 signed, two-stage pipeline
// S1 holds A plus per-digit neg/one/two flags; S2 holds the 64 column vectors.
module booth_pp_gen (
  input  logic           clk,
  input  logic           rst,
  booth_pp_gen_if.slave  bus
);

  logic        s1_valid;
  logic [31:0] a_q;
  logic [15:0] neg_q, one_q, two_q;
  logic [15:0] neg_d, one_d, two_d;
  logic [32:0] b_ext;
  logic        accept;
  logic        s2_load;
  logic        out_valid_q;
  logic [63:0] a_ext;
  logic [63:0] mag [16];
  logic [63:0] sgn [16];
  logic [63:0] pp  [16];
  logic [15:0] n_next [64];
  logic [15:0] n_q    [64];

  assign s2_load     = s1_valid && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid || s2_load;
  assign accept      = bus.in_valid && bus.in_ready;

  // Bit 0 of b_ext is the implicit B[-1] = 0.
  assign b_ext = {bus.B, 1'b0};

  // Triplet (b2k+1, b2k, b2k-1): 111 and 000 both encode zero, so neg is suppressed for 111.
  always_comb begin
    neg_d = '0;
    one_d = '0;
    two_d = '0;
    for (int k = 0; k < 16; k++) begin
      neg_d[k] = b_ext[2*k+2] & ~(b_ext[2*k+1] & b_ext[2*k]);
      one_d[k] = b_ext[2*k+1] ^ b_ext[2*k];
      two_d[k] = (b_ext[2*k+2] & ~b_ext[2*k+1] & ~b_ext[2*k]) |
                 (~b_ext[2*k+2] & b_ext[2*k+1] & b_ext[2*k]);
    end
  end

  assign a_ext = {{32{a_q[31]}}, a_q};

  // Full 64-bit sign extension before doubling keeps -2 * 0x80000000 exact.
  always_comb begin
    mag = '{default: '0};
    sgn = '{default: '0};
    pp  = '{default: '0};
    for (int k = 0; k < 16; k++) begin
      mag[k] = one_q[k] ? a_ext : (two_q[k] ? {a_ext[62:0], 1'b0} : 64'd0);
      sgn[k] = neg_q[k] ? (~mag[k] + 64'd1) : mag[k];
      pp[k]  = sgn[k] << (2 * k);
    end
  end

  always_comb begin
    n_next = '{default: '0};
    for (int j = 0; j < 64; j++) begin
      for (int k = 0; k < 16; k++) begin
        n_next[j][k] = pp[k][j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      a_q      <= '0;
      neg_q    <= '0;
      one_q    <= '0;
      two_q    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      a_q      <= bus.A;
      neg_q    <= neg_d;
      one_q    <= one_d;
      two_q    <= two_d;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      for (int j = 0; j < 64; j++) begin
        n_q[j] <= '0;
      end
    end else if (s2_load) begin
      out_valid_q <= 1'b1;
      n_q         <= n_next;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.N         = n_q;
  assign bus.Cin       = '0;

endmodule

// File: tb/tb_booth_pp_gen.sv
// tb/tb_booth_pp_gen.sv - self-checking bench for booth_pp_gen
module tb_booth_pp_gen;

  logic clk;
  logic rst;

  booth_pp_gen_if bus ();

  booth_pp_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] sum;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  int          total;
  int          bad;
  int          in_cnt;
  int          out_cnt;
  pair_t       exp_q [$];
  logic [15:0] snap_n [64];
  logic [15:0] hold_n [64];
  vec_t        vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // PP_k straight from the digit definition using signed integer arithmetic.
  function automatic logic [63:0] pp_model(input logic [31:0] a, input logic [31:0] b, input int k);
    int    d;
    longint p;
    d = -2 * int'(b[2*k+1]) + int'(b[2*k]);
    if (k > 0) d = d + int'(b[2*k-1]);
    p = longint'(d) * longint'($signed(a));
    return 64'(p) << (2 * k);
  endfunction

  function automatic logic [63:0] prod_model(input logic [31:0] a, input logic [31:0] b);
    return 64'(longint'($signed(a)) * longint'($signed(b)));
  endfunction

  task automatic take_snap();
    for (int j = 0; j < 64; j++) snap_n[j] = bus.N[j];
  endtask

  function automatic logic [63:0] col_sum();
    logic [63:0] s;
    s = '0;
    for (int j = 0; j < 64; j++)
      for (int k = 0; k < 16; k++)
        if (snap_n[j][k]) s = s + (64'd1 << j);
    return s;
  endfunction

  function automatic int nonzero_cols();
    int n;
    n = 0;
    for (int j = 0; j < 64; j++) if (snap_n[j] != 16'd0) n++;
    return n;
  endfunction

  task automatic check_pair(input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [63:0] ppk;
    int          nbad;
    take_snap();
    nbad = 0;
    for (int k = 0; k < 16; k++) begin
      ppk = pp_model(a, b, k);
      for (int j = 0; j < 64; j++) if (snap_n[j][k] !== ppk[j]) nbad++;
    end
    chk({nm, " column bits wrong"}, 64'(nbad), 64'd0);
    chk({nm, " column sum"}, col_sum(), prod_model(a, b));
    chk({nm, " Cin"}, 64'(bus.Cin), 64'd0);
  endtask

  task automatic check_out(input string nm);
    pair_t p;
    out_cnt++;
    if (exp_q.size() == 0) begin
      chk({nm, " unexpected output"}, 64'd1, 64'd0);
    end else begin
      p = exp_q.pop_front();
      check_pair(p.a, p.b, nm);
    end
  endtask

  // One clock: drive at negedge, observe handshakes just before the edge, return after it.
  task automatic cycle_step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                            input logic ordy, output logic acc);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.A         = a;
    bus.B         = b;
    bus.out_ready = ordy;
    #1;
    acc = iv && bus.in_ready;
    if (bus.out_valid && ordy) check_out("stream");
    if (acc) begin
      exp_q.push_back({a, b});
      in_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input vec_t v, input string nm);
    logic acc;
    int   lat;
    cycle_step(1'b1, v.a, v.b, 1'b1, acc);
    bus.in_valid = 1'b0;
    chk({nm, " accepted"}, 64'(acc), 64'd1);
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd2);
    check_out(nm);
    chk({nm, " table sum"}, col_sum(), v.sum);
    if (v.a == 32'd0) chk({nm, " zero columns"}, 64'(nonzero_cols()), 64'd0);
    @(posedge clk);
    #1;
    chk({nm, " out_valid cleared"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic        pending;
    logic [31:0] pa, pb;
    int          n, acc_cnt, s_in, s_out, cyc, nchg;
    logic        x3_done;

    total = 0; bad = 0; in_cnt = 0; out_cnt = 0;

    vecs[0] = '{32'd3,         32'd5,         64'd15};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'h0000000000000001};
    vecs[2] = '{32'h80000000,  32'h80000000,  64'h4000000000000000};
    vecs[3] = '{32'h7FFFFFFF,  32'h80000000,  64'hC000000080000000};
    vecs[4] = '{32'd0,         32'h12345678,  64'd0};
    vecs[5] = '{32'h80000000,  32'd2,         64'hFFFFFFFF00000000};
    vecs[6] = '{32'h12345678,  32'hFFFFFFFF,  64'hFFFFFFFFEDCBA988};
    vecs[7] = '{32'hFFFFFFFE,  32'h7FFFFFFF,  64'hFFFFFFFF00000002};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b0;
    #2;
    take_snap();
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset N", 64'(nonzero_cols()), 64'd0);
    chk("reset Cin", 64'(bus.Cin), 64'd0);
    #10;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: two accepted, third stalls, everything holds.
    acc_cnt = 0;
    cycle_step(1'b1, 32'd11, 32'd13, 1'b0, acc); acc_cnt += int'(acc);
    cycle_step(1'b1, 32'hFFFFFFF9, 32'd17, 1'b0, acc); acc_cnt += int'(acc);
    cycle_step(1'b1, 32'h80000000, 32'h55555555, 1'b0, acc); acc_cnt += int'(acc);
    chk("bp accepted count", 64'(acc_cnt), 64'd2);
    chk("bp in_ready low", 64'(bus.in_ready), 64'd0);
    chk("bp out_valid high", 64'(bus.out_valid), 64'd1);
    for (int j = 0; j < 64; j++) hold_n[j] = bus.N[j];
    for (int i = 0; i < 3; i++) begin
      cycle_step(1'b1, 32'h80000000, 32'h55555555, 1'b0, acc);
      chk("bp stalled accept", 64'(acc), 64'd0);
    end
    nchg = 0;
    for (int j = 0; j < 64; j++) if (bus.N[j] !== hold_n[j]) nchg++;
    chk("bp N stable", 64'(nchg), 64'd0);
    s_out = out_cnt;
    x3_done = 1'b0;
    n = 0;
    while ((exp_q.size() > 0 || !x3_done) && n < 12) begin
      cycle_step(!x3_done, 32'h80000000, 32'h55555555, 1'b1, acc);
      if (acc) x3_done = 1'b1;
      n++;
    end
    chk("bp third accepted", 64'(x3_done), 64'd1);
    chk("bp drained", 64'(exp_q.size()), 64'd0);
    chk("bp outputs", 64'(out_cnt - s_out), 64'd3);

    // Randomized streaming against the arithmetic model.
    s_in = in_cnt; s_out = out_cnt; pending = 1'b0; cyc = 0; pa = '0; pb = '0;
    while (in_cnt - s_in < 1000 && cyc < 20000) begin
      if (!pending && ($urandom % 4 != 0)) begin
        case ($urandom % 8)
          0: pa = 32'h80000000;
          1: pa = 32'd0;
          2: pa = 32'hFFFFFFFF;
          default: pa = $urandom;
        endcase
        pb = ($urandom % 8 == 0) ? 32'h80000000 : $urandom;
        pending = 1'b1;
      end
      cycle_step(pending, pa, pb, ($urandom % 3 != 0), acc);
      if (acc) pending = 1'b0;
      cyc++;
    end
    chk("stream in budget", 64'(cyc < 20000), 64'd1);
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      cycle_step(1'b0, 32'd0, 32'd0, 1'b1, acc);
      n++;
    end
    chk("stream drained", 64'(exp_q.size()), 64'd0);
    chk("stream count in", 64'(in_cnt - s_in), 64'd1000);
    chk("stream count out", 64'(out_cnt - s_out), 64'd1000);

    // Reset while both stages hold data.
    cycle_step(1'b1, 32'd1234, 32'd4321, 1'b0, acc);
    cycle_step(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, acc);
    chk("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    take_snap();
    chk("async reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("async reset N", 64'(nonzero_cols()), 64'd0);
    chk("async reset in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    s_out = out_cnt;
    for (int i = 0; i < 4; i++) cycle_step(1'b0, 32'd0, 32'd0, 1'b1, acc);
    chk("no stale output", 64'(out_cnt - s_out), 64'd0);
    run_vector(vecs[0], "post-reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
